// File: rtl/riscv_counter_reader.sv
// Bus-side reader for a free-running 64-bit counter: coherent LO/HI reads via a
// high-half snapshot, a 64-bit compare register and a registered level interrupt.
module riscv_counter_reader #(
   parameter int DATA_WIDTH    = 32,
   parameter int COUNTER_WIDTH = 2 * DATA_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [COUNTER_WIDTH-1:0] count_in,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [1:0]               req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_WIDTH-1:0]    rsp_rdata,
   output logic                     cmp_irq
);

   typedef enum logic {
      IDLE = 1'b0,
      RESP = 1'b1
   } state_t;

   localparam logic [1:0] ADDR_CNT_LO = 2'd0;
   localparam logic [1:0] ADDR_CNT_HI = 2'd1;
   localparam logic [1:0] ADDR_CMP_LO = 2'd2;
   localparam logic [1:0] ADDR_CMP_HI = 2'd3;

   state_t                   state_q, state_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]    hi_snap_q, hi_snap_d;
   logic [COUNTER_WIDTH-1:0] cmp_q, cmp_d;
   logic                     irq_q, irq_d;
   logic                     accept;

   always_comb begin
      state_d   = state_q;
      rdata_d   = rdata_q;
      hi_snap_d = hi_snap_q;
      cmp_d     = cmp_q;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      accept    = 1'b0;

      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Read data is captured once at accept so it stays frozen through RESP.
      if (accept) begin
         rdata_d = '0;
         if (req_write) begin
            case (req_addr)
               ADDR_CMP_LO: cmp_d[DATA_WIDTH-1:0]             = req_wdata;
               ADDR_CMP_HI: cmp_d[COUNTER_WIDTH-1:DATA_WIDTH] = req_wdata;
               default: ;
            endcase
         end else begin
            case (req_addr)
               ADDR_CNT_LO: begin
                  rdata_d   = count_in[DATA_WIDTH-1:0];
                  hi_snap_d = count_in[COUNTER_WIDTH-1:DATA_WIDTH];
               end
               ADDR_CNT_HI: rdata_d = hi_snap_q;
               ADDR_CMP_LO: rdata_d = cmp_q[DATA_WIDTH-1:0];
               ADDR_CMP_HI: rdata_d = cmp_q[COUNTER_WIDTH-1:DATA_WIDTH];
               default: ;
            endcase
         end
      end

      // Compares against the registered cmp, so a CMP write lands one cycle later.
      irq_d = (count_in >= cmp_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         rdata_q   <= '0;
         hi_snap_q <= '0;
         cmp_q     <= '1;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdata_q   <= rdata_d;
         hi_snap_q <= hi_snap_d;
         cmp_q     <= cmp_d;
         irq_q     <= irq_d;
      end
   end

   assign rsp_rdata = rdata_q;
   assign cmp_irq   = irq_q;

endmodule
